stack_ctrl: RTL and testbench

//   Sequences a bank of DEPTH 16-bit datapath registers as a LIFO operand stack.

---
 rtl/stack_ctrl.sv | 161 ++++++++++++++++
 tb/tb_stack_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// LIFO operand-stack controller: owns the stack pointer and drives one-hot
// write enables, write data and a top-of-stack read select for an external bank.
module stack_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_ready,
  input  logic             err_clr,
  output logic [DEPTH-1:0] reg_write,
  output logic [WIDTH-1:0] w_data,
  output logic [SP_W-1:0]  rd_sel,
  output logic [SP_W-1:0]  sp,
  output logic             empty,
  output logic             full,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_PUSH    = 2'b01;
  localparam logic [1:0] OP_POP     = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OVER  = 2'b01;
  localparam logic [1:0] ERR_UNDER = 2'b10;

  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    ERR   = 2'b10
  } state_t;

  state_t           state, state_n;
  logic [SP_W-1:0]  sp_q, sp_n;
  logic [DEPTH-1:0] reg_write_q, reg_write_n;
  logic [WIDTH-1:0] w_data_q, w_data_n;
  logic             err_q, err_n;
  logic [1:0]       err_code_q, err_code_n;
  logic             is_empty, is_full;

  function automatic logic [DEPTH-1:0] onehot(input logic [SP_W-1:0] idx);
    logic [DEPTH-1:0] oh;
    oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      oh[i] = (idx == SP_W'(i));
    end
    return oh;
  endfunction

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == SP_FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    sp_n        = sp_q;
    reg_write_n = '0;
    w_data_n    = w_data_q;
    err_n       = err_q;
    err_code_n  = err_code_q;
    unique case (state)
      IDLE: begin
        if (op_valid) begin
          unique case (op_code)
            OP_PUSH: begin
              if (is_full) begin
                err_n      = 1'b1;
                err_code_n = ERR_OVER;
                state_n    = ERR;
              end else begin
                reg_write_n = onehot(sp_q);
                w_data_n    = op_data;
                sp_n        = sp_q + SP_ONE;
                state_n     = WRITE;
              end
            end
            OP_POP: begin
              if (is_empty) begin
                err_n      = 1'b1;
                err_code_n = ERR_UNDER;
                state_n    = ERR;
              end else begin
                sp_n = sp_q - SP_ONE;
              end
            end
            OP_REPLACE: begin
              if (is_empty) begin
                err_n      = 1'b1;
                err_code_n = ERR_UNDER;
                state_n    = ERR;
              end else begin
                reg_write_n = onehot(sp_q - SP_ONE);
                w_data_n    = op_data;
                state_n     = WRITE;
              end
            end
            default: ;
          endcase
        end
      end
      // The bank samples reg_write/w_data on the negedge inside this cycle.
      WRITE: begin
        state_n = IDLE;
      end
      ERR: begin
        if (err_clr) begin
          err_n      = 1'b0;
          err_code_n = ERR_NONE;
          state_n    = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q        <= '0;
      reg_write_q <= '0;
      w_data_q    <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      sp_q        <= sp_n;
      reg_write_q <= reg_write_n;
      w_data_q    <= w_data_n;
      err_q       <= err_n;
      err_code_q  <= err_code_n;
    end
  end

  assign op_ready  = (state == IDLE);
  assign reg_write = reg_write_q;
  assign w_data    = w_data_q;
  assign sp        = sp_q;
  assign rd_sel    = is_empty ? '0 : (sp_q - SP_ONE);
  assign empty     = is_empty;
  assign full      = is_full;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl (DEPTH=4): scoreboard queue of expected
// register-bank writes plus immediate checks of pointer/flag state.
module tb_stack_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int SP_W  = $clog2(DEPTH + 1);

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_PUSH    = 2'b01;
  localparam logic [1:0] OP_POP     = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  logic             clk = 1'b0;
  logic             reset;
  logic             op_valid;
  logic [1:0]       op_code;
  logic [WIDTH-1:0] op_data;
  logic             op_ready;
  logic             err_clr;
  logic [DEPTH-1:0] reg_write;
  logic [WIDTH-1:0] w_data;
  logic [SP_W-1:0]  rd_sel;
  logic [SP_W-1:0]  sp;
  logic             empty;
  logic             full;
  logic             err;
  logic [1:0]       err_code;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [DEPTH+WIDTH-1:0] exp_q[$];

  stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_data  (op_data),
    .op_ready (op_ready),
    .err_clr  (err_clr),
    .reg_write(reg_write),
    .w_data   (w_data),
    .rd_sel   (rd_sel),
    .sp       (sp),
    .empty    (empty),
    .full     (full),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // Every non-zero write seen by the bank must match the oldest expectation.
  always @(negedge clk) begin
    if (reg_write !== '0) begin
      logic [DEPTH+WIDTH-1:0] e;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {12'd0, reg_write, w_data}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_write", {12'd0, reg_write, w_data}, {12'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] code, input logic [WIDTH-1:0] data);
    op_valid = 1'b1;
    op_code  = code;
    op_data  = data;
    tick();
    op_valid = 1'b0;
    op_code  = OP_NOP;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic [DEPTH-1:0] oh;
    reset    = 1'b1;
    op_valid = 1'b0;
    op_code  = OP_NOP;
    op_data  = '0;
    err_clr  = 1'b0;
    tick();
    tick();
    check("rst_sp", 32'(sp), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ready", 32'(op_ready), 32'd1);
    check("rst_wr", 32'(reg_write), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    check("rst_wdata", 32'(w_data), 32'd0);
    reset = 1'b0;
    tick();

    // Fill the stack.
    for (int i = 0; i < DEPTH; i++) begin
      d  = WIDTH'(16'h1111 * (i + 1));
      oh = DEPTH'(1) << i;
      exp_q.push_back({oh, d});
      issue(OP_PUSH, d);
      check("push_wr", 32'(reg_write), 32'(oh));
      check("push_wready", 32'(op_ready), 32'd0);
      check("push_sp", 32'(sp), 32'(i + 1));
      check("push_rdsel", 32'(rd_sel), 32'(i));
      tick();
      check("push_done_wr", 32'(reg_write), 32'd0);
      check("push_done_ready", 32'(op_ready), 32'd1);
    end
    check("full_flag", 32'(full), 32'd1);
    check("full_rdsel", 32'(rd_sel), 32'd3);

    // Overflow, ignored request in ERR, then recover.
    issue(OP_PUSH, 16'h5555);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_code", 32'(err_code), 32'd1);
    check("ovf_ready", 32'(op_ready), 32'd0);
    check("ovf_wr", 32'(reg_write), 32'd0);
    check("ovf_sp", 32'(sp), 32'd4);
    issue(OP_POP, 16'h0);
    check("errst_sp", 32'(sp), 32'd4);
    check("errst_err", 32'(err), 32'd1);
    clear_err();
    check("clr_err", 32'(err), 32'd0);
    check("clr_code", 32'(err_code), 32'd0);
    check("clr_ready", 32'(op_ready), 32'd1);
    check("clr_sp", 32'(sp), 32'd4);

    // Back-to-back pops, one per cycle.
    op_valid = 1'b1;
    op_code  = OP_POP;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check("pop_sp", 32'(sp), 32'(DEPTH - 1 - i));
      check("pop_ready", 32'(op_ready), 32'd1);
      check("pop_rdsel", 32'(rd_sel), (i == DEPTH - 1) ? 32'd0 : 32'(DEPTH - 2 - i));
    end
    op_valid = 1'b0;
    op_code  = OP_NOP;
    check("pop_empty", 32'(empty), 32'd1);
    issue(OP_POP, 16'h0);
    check("udf_code", 32'(err_code), 32'd2);
    check("udf_sp", 32'(sp), 32'd0);
    clear_err();

    // err_clr outside ERR does nothing.
    clear_err();
    check("idle_clr_sp", 32'(sp), 32'd0);
    check("idle_clr_ready", 32'(op_ready), 32'd1);

    // Replace top-of-stack.
    exp_q.push_back({DEPTH'(1), 16'hAAAA});
    issue(OP_PUSH, 16'hAAAA);
    tick();
    exp_q.push_back({DEPTH'(1), 16'hBBBB});
    issue(OP_REPLACE, 16'hBBBB);
    check("rep_wr", 32'(reg_write), 32'd1);
    check("rep_wdata", 32'(w_data), 32'hBBBB);
    check("rep_sp", 32'(sp), 32'd1);
    tick();
    issue(OP_POP, 16'h0);
    check("rep_pop_sp", 32'(sp), 32'd0);
    issue(OP_REPLACE, 16'hCCCC);
    check("rep_empty_code", 32'(err_code), 32'd2);
    check("rep_empty_wr", 32'(reg_write), 32'd0);
    clear_err();

    // Reset arriving during the WRITE cycle.
    exp_q.push_back({DEPTH'(1), 16'h7777});
    issue(OP_PUSH, 16'h7777);
    check("mid_wr_state", 32'(op_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_wr", 32'(reg_write), 32'd0);
    check("mid_rst_sp", 32'(sp), 32'd0);
    check("mid_rst_ready", 32'(op_ready), 32'd1);
    check("mid_rst_wdata", 32'(w_data), 32'd0);

    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
